// File: rtl/s2_control_pipe.sv
// Stage-2 control for the 3-stage RV32IM core: decode, operand forwarding,
// load-use interlock, M-extension stall sequencing and the s2->s3 control register.
module s2_control_pipe #(
  parameter bit MULDIV_EN  = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int RF_AW      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction_s2,
  input  logic             valid_s2,
  input  logic             flush,
  input  logic [RF_AW-1:0] rd_s4,
  input  logic             regwen_s4,
  output logic [1:0]       rs1_sel,
  output logic [1:0]       rs2_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic             brun,
  output logic [3:0]       alu_sel,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic             stall,
  output logic             valid_s3,
  output logic             regwen_s3,
  output logic             mem_wen_s3,
  output logic             is_load_s3,
  output logic [RF_AW-1:0] rd_s3
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  localparam int N_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W = $clog2(N_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [RF_AW-1:0] rd_s2, rs1_s2, rs2_s2;
  logic             is_lui, is_auipc, is_jal, is_branch, is_load, is_store, is_imm, is_reg;
  logic             is_mext, m_op, illegal, op_ok;
  logic             use_rs1, use_rs2, s3_fwd_ok, load_use, m_go, mem_wen;
  logic [CNT_W-1:0] m_len_m1;

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? 4'd12 : 4'd0;
      3'b001:  code = 4'd1;
      3'b010:  code = 4'd2;
      3'b011:  code = 4'd11;
      3'b100:  code = 4'd4;
      3'b101:  code = alt ? 4'd13 : 4'd5;
      3'b110:  code = 4'd6;
      default: code = 4'd7;
    endcase
    return code;
  endfunction

  assign opcode = instruction_s2[6:0];
  assign funct3 = instruction_s2[14:12];
  assign funct7 = instruction_s2[31:25];
  assign rd_s2  = instruction_s2[7 +: RF_AW];
  assign rs1_s2 = instruction_s2[15 +: RF_AW];
  assign rs2_s2 = instruction_s2[20 +: RF_AW];

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_imm    = (opcode == OPC_IMM);
  assign is_reg    = (opcode == OPC_REG);

  // With the M unit compiled out, M encodings flow down the pipe as bubbles
  assign is_mext = is_reg && (funct7 == 7'b0000001);
  assign m_op    = is_mext && (MULDIV_EN == 1'b1);
  assign illegal = is_mext && (MULDIV_EN == 1'b0);
  assign op_ok   = valid_s2 && !illegal;

  assign use_rs1 = !(is_lui || is_auipc || is_jal);
  assign use_rs2 = is_reg || is_store || is_branch;

  always_comb begin
    alu_sel = 4'd0;
    if (is_lui)
      alu_sel = 4'd15;
    else if (is_imm)
      alu_sel = alu_code(funct3, instruction_s2[30] && (funct3 == 3'b101));
    else if (is_reg && !is_mext)
      alu_sel = alu_code(funct3, instruction_s2[30]);
  end

  assign a_sel = is_auipc || is_jal || is_branch;
  assign b_sel = !is_reg;
  assign brun  = is_branch && funct3[1];
  assign md_op = funct3;

  // Loads in s3 have no data yet; they are covered by the load-use interlock instead
  assign s3_fwd_ok = valid_s3 && regwen_s3 && !is_load_s3;

  always_comb begin
    rs1_sel = 2'b00;
    rs2_sel = 2'b00;
    if (use_rs1 && (rs1_s2 != '0)) begin
      if (s3_fwd_ok && (rs1_s2 == rd_s3))
        rs1_sel = 2'b10;
      else if (regwen_s4 && (rs1_s2 == rd_s4))
        rs1_sel = 2'b01;
    end
    if (use_rs2 && (rs2_s2 != '0)) begin
      if (s3_fwd_ok && (rs2_s2 == rd_s3))
        rs2_sel = 2'b10;
      else if (regwen_s4 && (rs2_s2 == rd_s4))
        rs2_sel = 2'b01;
    end
  end

  assign load_use = op_ok && valid_s3 && is_load_s3 && (rd_s3 != '0) &&
                    ((use_rs1 && (rs1_s2 == rd_s3)) || (use_rs2 && (rs2_s2 == rd_s3)));

  assign m_go     = op_ok && m_op && !flush && !load_use && (md_state == IDLE);
  assign m_len_m1 = funct3[2] ? DIV_LOAD : MUL_LOAD;
  assign md_start = rst_n && m_go;
  assign stall    = rst_n && !flush && (load_use || m_go || (md_state == BUSY));
  assign mem_wen  = is_store && valid_s2 && !stall && !flush;

  // M-op sequencer: the launch cycle plus the BUSY cycles make up the N stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state <= IDLE;
      md_cnt   <= '0;
    end else if (flush) begin
      md_state <= IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        IDLE: begin
          if (m_go) begin
            if (m_len_m1 == '0) begin
              md_state <= DONE;
              md_cnt   <= '0;
            end else begin
              md_state <= BUSY;
              md_cnt   <= m_len_m1;
            end
          end
        end
        BUSY: begin
          md_cnt <= md_cnt - CNT_W'(1);
          if (md_cnt <= CNT_W'(1)) begin
            md_state <= DONE;
            md_cnt   <= '0;
          end
        end
        default: begin
          md_state <= IDLE;
          md_cnt   <= '0;
        end
      endcase
    end
  end

  // s2 -> s3 control register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s3   <= 1'b0;
      regwen_s3  <= 1'b0;
      mem_wen_s3 <= 1'b0;
      is_load_s3 <= 1'b0;
      rd_s3      <= '0;
    end else if (stall || flush || !op_ok) begin
      valid_s3   <= 1'b0;
      regwen_s3  <= 1'b0;
      mem_wen_s3 <= 1'b0;
      is_load_s3 <= 1'b0;
      rd_s3      <= '0;
    end else begin
      valid_s3   <= 1'b1;
      regwen_s3  <= !(is_store || is_branch) && (rd_s2 != '0);
      mem_wen_s3 <= mem_wen;
      is_load_s3 <= is_load;
      rd_s3      <= rd_s2;
    end
  end

endmodule

// File: tb/tb_s2_control_pipe.sv
// Bench for s2_control_pipe: directed scenarios plus a randomized run against
// a cycle-stamp reference model of decode, forwarding, interlocks and M-op timing.
module tb_s2_control_pipe;

  localparam int RF_AW = 5;
  localparam int MUL_N = 4;
  localparam int DIV_N = 33;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instruction_s2;
  logic             valid_s2;
  logic             flush;
  logic [RF_AW-1:0] rd_s4;
  logic             regwen_s4;
  logic [1:0]       rs1_sel, rs2_sel;
  logic             a_sel, b_sel, brun;
  logic [3:0]       alu_sel;
  logic             md_start;
  logic [2:0]       md_op;
  logic             stall;
  logic             valid_s3, regwen_s3, mem_wen_s3, is_load_s3;
  logic [RF_AW-1:0] rd_s3;

  int tests_run    = 0;
  int tests_failed = 0;

  s2_control_pipe #(
    .MULDIV_EN(1'b1), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .RF_AW(RF_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instruction_s2(instruction_s2), .valid_s2(valid_s2),
    .flush(flush), .rd_s4(rd_s4), .regwen_s4(regwen_s4),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .a_sel(a_sel), .b_sel(b_sel), .brun(brun),
    .alu_sel(alu_sel), .md_start(md_start), .md_op(md_op), .stall(stall),
    .valid_s3(valid_s3), .regwen_s3(regwen_s3), .mem_wen_s3(mem_wen_s3),
    .is_load_s3(is_load_s3), .rd_s3(rd_s3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl,
                       input logic [4:0] r4, input logic w4);
    instruction_s2 = ins;
    valid_s2       = v;
    flush          = fl;
    rd_s4          = r4;
    regwen_s4      = w4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU-select table, by mnemonic
  function automatic logic [3:0] exp_alu(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;
    op  = ins[6:0];
    f3  = ins[14:12];
    b30 = ins[30];
    if (op == 7'b0110111) return 4'd15;
    if (op == 7'b0110011 && ins[31:25] == 7'b0000001) return 4'd0;
    if (op != 7'b0010011 && op != 7'b0110011) return 4'd0;
    case (f3)
      3'd0: return (op == 7'b0110011 && b30) ? 4'd12 : 4'd0;
      3'd1: return 4'd1;
      3'd2: return 4'd2;
      3'd3: return 4'd11;
      3'd4: return 4'd4;
      3'd5: return b30 ? 4'd13 : 4'd5;
      3'd6: return 4'd6;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [1:0] exp_sel(input logic used, input logic [4:0] rs,
                                         input logic s3v, input logic s3w, input logic s3l,
                                         input logic [4:0] s3rd, input logic [4:0] r4,
                                         input logic w4);
    if (!used || rs == 5'd0) return 2'd0;
    if (s3v && s3w && !s3l && rs == s3rd) return 2'd2;
    if (w4 && rs == r4) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    int          k;
    w        = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    f3       = 3'($urandom_range(0, 7));
    k        = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2: w[6:0] = 7'b1101111;
      3: begin w[6:0] = 7'b1100111; w[14:12] = 3'b000; end
      4: begin w[6:0] = 7'b1100011; w[14:12] = (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3; end
      5: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
      6: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
      7, 8: begin
        w[6:0]   = 7'b0010011;
        w[14:12] = f3;
        if (f3 == 3'd1) w[31:25] = 7'b0;
        else if (f3 == 3'd5) w[31:25] = {1'b0, w[30], 5'b0};
      end
      9, 10: begin
        w[6:0]   = 7'b0110011;
        w[14:12] = f3;
        w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && w[30]) ? 7'b0100000 : 7'b0;
      end
      default: begin
        w[6:0]   = 7'b0110011;
        w[31:25] = 7'b0000001;
        w[14:12] = ($urandom_range(0, 3) == 0) ? f3 : {1'b0, f3[1:0]};
      end
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(enc_r(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7), 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({valid_s3, regwen_s3, mem_wen_s3, is_load_s3, rd_s3, stall, md_start} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b w=%b mw=%b ld=%b rd=%0d stall=%b start=%b, want all 0",
               valid_s3, regwen_s3, mem_wen_s3, is_load_s3, rd_s3, stall, md_start);
    end
    valid_s2 = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset_busy();
    drive(enc_r(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7), 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (23) next_cycle();
    rst_n = 1'b0;
    drive(enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011), 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    tests_run++;
    if (stall !== 1'b0 || valid_s3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy_async: got stall=%b valid_s3=%b, want 0 0", stall, valid_s3);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (md_start !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy_idle: got md_start=%b stall=%b, want 0 0", md_start, stall);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b1 || rd_s3 !== 5'd1) begin
      tests_failed++;
      $display("FAIL reset_busy_advance: got valid_s3=%b rd_s3=%0d, want 1 1", valid_s3, rd_s3);
    end
  endtask

  task automatic test_forward();
    drive(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive(enc_r(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd5), 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (rs1_sel !== 2'b10 || rs2_sel !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_s3: got rs1_sel=%b rs2_sel=%b, want 10 10", rs1_sel, rs2_sel);
    end
    tests_run++;
    if (alu_sel !== 4'd12 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_sub_decode: got alu_sel=%0d stall=%b, want 12 0", alu_sel, stall);
    end
    next_cycle();
    drive(enc_r(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd5), 1'b1, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rs1_sel !== 2'b01 || rs2_sel !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_s4: got rs1_sel=%b rs2_sel=%b, want 01 01", rs1_sel, rs2_sel);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    drive(enc_i(12'd0, 5'd1, 3'b010, 5'd4, 7'b0000011), 1'b1, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive(enc_i(12'd1, 5'd4, 3'b000, 5'd6, 7'b0010011), 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_stall: got stall=%b, want 1", stall);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got valid_s3=%b, want 0", valid_s3);
    end
    drive(enc_i(12'd1, 5'd4, 3'b000, 5'd6, 7'b0010011), 1'b1, 1'b0, 5'd4, 1'b1);
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || rs1_sel !== 2'b01 || alu_sel !== 4'd0) begin
      tests_failed++;
      $display("FAIL load_use_resume: got stall=%b rs1_sel=%b alu_sel=%0d, want 0 01 0",
               stall, rs1_sel, alu_sel);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b1 || rd_s3 !== 5'd6) begin
      tests_failed++;
      $display("FAIL load_use_advance: got valid_s3=%b rd_s3=%0d, want 1 6", valid_s3, rd_s3);
    end
  endtask

  task automatic test_div();
    int  stall_cnt;
    int  pulses;
    bit  finished;
    drive(enc_r(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7), 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (md_start !== 1'b1 || md_op !== 3'b100 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_launch: got md_start=%b md_op=%b stall=%b, want 1 100 1",
               md_start, md_op, stall);
    end
    stall_cnt = 0;
    pulses    = 0;
    finished  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (md_start === 1'b1) pulses++;
      if (stall !== 1'b1) begin
        finished = 1'b1;
        break;
      end
      stall_cnt++;
      next_cycle();
      if (i == 0) begin
        tests_run++;
        if (valid_s3 !== 1'b0) begin
          tests_failed++;
          $display("FAIL div_bubble: got valid_s3=%b, want 0", valid_s3);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (!finished) begin
      tests_failed++;
      $display("FAIL div_timeout: stall still high after 100 cycles, want release");
    end
    tests_run++;
    if (stall_cnt != DIV_N) begin
      tests_failed++;
      $display("FAIL div_stall_len: got %0d stalled cycles, want %0d", stall_cnt, DIV_N);
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL div_start_pulses: got %0d, want 1", pulses);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b1 || rd_s3 !== 5'd7 || regwen_s3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_done: got valid_s3=%b rd_s3=%0d regwen_s3=%b, want 1 7 1",
               valid_s3, rd_s3, regwen_s3);
    end
  endtask

  task automatic test_flush();
    logic [31:0] mul_i;
    mul_i = enc_r(7'b0000001, 5'd12, 5'd11, 3'b000, 5'd10);
    drive(mul_i, 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) next_cycle();
    drive(mul_i, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || md_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_busy: got stall=%b md_start=%b, want 0 0", stall, md_start);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_bubble: got valid_s3=%b, want 0", valid_s3);
    end
    drive(enc_i(12'b0100000_00011, 5'd1, 3'b101, 5'd1, 7'b0010011), 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (alu_sel !== 4'd13 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL srai_decode: got alu_sel=%0d stall=%b, want 13 0", alu_sel, stall);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_idle_advance: got valid_s3=%b, want 1", valid_s3);
    end
    drive(enc_i(12'h400, 5'd2, 3'b000, 5'd2, 7'b0010011), 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (alu_sel !== 4'd0) begin
      tests_failed++;
      $display("FAIL addi_bit30: got alu_sel=%0d, want 0", alu_sel);
    end
    next_cycle();
    drive(mul_i, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (md_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_relaunch: got md_start=%b, want 1", md_start);
    end
    next_cycle();
    drive(mul_i, 1'b1, 1'b1, 5'd0, 1'b0);
    next_cycle();
  endtask

  task automatic test_store();
    drive(enc_s(12'd4, 5'd0, 5'd2, 3'b010), 1'b1, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rs2_sel !== 2'b00 || rs1_sel !== 2'b00 || b_sel !== 1'b1 || a_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_decode: got rs1_sel=%b rs2_sel=%b a_sel=%b b_sel=%b, want 00 00 0 1",
               rs1_sel, rs2_sel, a_sel, b_sel);
    end
    next_cycle();
    tests_run++;
    if (valid_s3 !== 1'b1 || mem_wen_s3 !== 1'b1 || regwen_s3 !== 1'b0 || rd_s3 !== 5'd4) begin
      tests_failed++;
      $display("FAIL store_s3: got valid=%b mem_wen=%b regwen=%b rd=%0d, want 1 1 0 4",
               valid_s3, mem_wen_s3, regwen_s3, rd_s3);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        v, fl, w4, hold;
    logic [4:0]  r4, rd, rs1, rs2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        k_lui, k_auipc, k_jal, k_br, k_ld, k_st, k_op, k_m, u1, u2, lu;
    logic        e_stall, e_start, nxt_active;
    logic [1:0]  e_s1, e_s2;
    logic        m3_v, m3_w, m3_mw, m3_ld;
    logic [4:0]  m3_rd;
    bit          m_active;
    int          m_release, cyc;

    next_cycle();
    rst_n = 1'b0;
    drive(32'h0000_0013, 1'b0, 1'b0, 5'd0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    {m3_v, m3_w, m3_mw, m3_ld, m3_rd} = '0;
    m_active  = 1'b0;
    m_release = 0;
    cyc       = 0;
    hold      = 1'b0;
    ins       = 32'h0000_0013;
    v         = 1'b0;

    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        ins = rand_instr();
        v   = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 24) == 0);
      r4 = 5'($urandom_range(0, 3));
      w4 = 1'($urandom_range(0, 1));
      drive(ins, v, fl, r4, w4);

      op  = ins[6:0];
      f3  = ins[14:12];
      rd  = ins[11:7];
      rs1 = ins[19:15];
      rs2 = ins[24:20];
      k_lui   = (op == 7'b0110111);
      k_auipc = (op == 7'b0010111);
      k_jal   = (op == 7'b1101111);
      k_br    = (op == 7'b1100011);
      k_ld    = (op == 7'b0000011);
      k_st    = (op == 7'b0100011);
      k_op    = (op == 7'b0110011);
      k_m     = k_op && (ins[31:25] == 7'b0000001);
      u1      = !(k_lui || k_auipc || k_jal);
      u2      = k_op || k_st || k_br;
      e_s1    = exp_sel(u1, rs1, m3_v, m3_w, m3_ld, m3_rd, r4, w4);
      e_s2    = exp_sel(u2, rs2, m3_v, m3_w, m3_ld, m3_rd, r4, w4);
      lu      = v && m3_v && m3_ld && (m3_rd != 5'd0) &&
                ((u1 && rs1 == m3_rd) || (u2 && rs2 == m3_rd));

      e_start    = 1'b0;
      nxt_active = 1'b0;
      if (fl) begin
        e_stall = 1'b0;
      end else if (m_active) begin
        e_stall    = (cyc < m_release);
        nxt_active = e_stall;
      end else if (lu) begin
        e_stall = 1'b1;
      end else if (v && k_m) begin
        e_start    = 1'b1;
        e_stall    = 1'b1;
        nxt_active = 1'b1;
        m_release  = cyc + (f3[2] ? DIV_N : MUL_N);
      end else begin
        e_stall = 1'b0;
      end

      @(negedge clk);
      tests_run++;
      if (stall !== e_stall || md_start !== e_start) begin
        tests_failed++;
        $display("FAIL rnd_stall cyc %0d ins %h: got stall=%b start=%b, want %b %b",
                 cyc, ins, stall, md_start, e_stall, e_start);
      end
      tests_run++;
      if (rs1_sel !== e_s1 || rs2_sel !== e_s2) begin
        tests_failed++;
        $display("FAIL rnd_fwd cyc %0d ins %h: got %b %b, want %b %b",
                 cyc, ins, rs1_sel, rs2_sel, e_s1, e_s2);
      end
      tests_run++;
      if (alu_sel !== exp_alu(ins) || a_sel !== (k_auipc || k_jal || k_br) ||
          b_sel !== !k_op || brun !== (k_br && f3[1])) begin
        tests_failed++;
        $display("FAIL rnd_decode cyc %0d ins %h: got alu=%0d a=%b b=%b brun=%b, want alu=%0d",
                 cyc, ins, alu_sel, a_sel, b_sel, brun, exp_alu(ins));
      end
      if (e_start) begin
        tests_run++;
        if (md_op !== f3) begin
          tests_failed++;
          $display("FAIL rnd_md_op cyc %0d: got %b, want %b", cyc, md_op, f3);
        end
      end

      if (e_stall || fl || !v) begin
        {m3_v, m3_w, m3_mw, m3_ld, m3_rd} = '0;
      end else begin
        m3_v  = 1'b1;
        m3_rd = rd;
        m3_w  = !(k_st || k_br) && (rd != 5'd0);
        m3_mw = k_st;
        m3_ld = k_ld;
      end
      m_active = nxt_active;
      hold     = e_stall;
      cyc++;

      next_cycle();
      tests_run++;
      if ({valid_s3, regwen_s3, mem_wen_s3, is_load_s3, rd_s3} !==
          {m3_v, m3_w, m3_mw, m3_ld, m3_rd}) begin
        tests_failed++;
        $display("FAIL rnd_s3 cyc %0d: got v=%b w=%b mw=%b ld=%b rd=%0d, want v=%b w=%b mw=%b ld=%b rd=%0d",
                 cyc, valid_s3, regwen_s3, mem_wen_s3, is_load_s3, rd_s3,
                 m3_v, m3_w, m3_mw, m3_ld, m3_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    next_cycle();
    test_reset_busy();
    test_forward();
    test_load_use();
    test_div();
    test_flush();
    test_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/s2_control_pipe.md
Name: s2_control_pipe

Overview:
- Stage-2 (decode/execute) control unit for the 3-stage RV32IM core.
- Decodes the s2 instruction into ALU/operand/branch controls.
- Computes operand-forwarding selects from downstream destinations, and detects load-use hazards.
- Sequences multi-cycle M-extension ops with a stall FSM, and owns the s2→s3 control pipeline register.

Parameters:
MULDIV_EN, 1, 1 = decode/sequence M-extension ops; 0 = treat opcode 0110011/funct7=0000001 as illegal (bubble).
MUL_CYCLES, 4, cycles an MUL* op occupies s2 (≥1).
DIV_CYCLES, 33, cycles a DIV*/REM* op occupies s2 (≥1).
RF_AW, 5, register-address width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instruction_s2  in  32  instruction in s2
valid_s2  in  1  s2 holds a real instruction
flush  in  1  redirect from s3 (branch/jump taken); kills s2 instruction
rd_s4  in  RF_AW  writeback-stage destination
regwen_s4  in  1  writeback-stage write enable
rs1_sel  out  2  00 regfile, 01 s4 writeback data, 10 s3 ALU result
rs2_sel  out  2  same encoding
a_sel  out  1  1 = PC operand (AUIPC, JAL, BRANCH)
b_sel  out  1  1 = immediate (all except R-type)
brun  out  1  unsigned branch compare (funct3[1])
alu_sel  out  4  0 ADD, 1 SLL, 2 SLT, 4 XOR, 5 SRL, 6 OR, 7 AND, 11 SLTU, 12 SUB, 13 SRA, 15 PASS_B
md_start  out  1  one-cycle pulse launching the M-unit
md_op  out  3  funct3 of the M op
stall  out  1  hold PC/s1/s2; s3 receives a bubble
valid_s3, regwen_s3, mem_wen_s3, is_load_s3  out  1  registered s3 controls
rd_s3  out  RF_AW  registered s3 destination

Behaviour:
- Reset (async, rst_n=0):
  - All s3 registers are 0.
  - FSM is IDLE and the counter is 0.
  - stall=0 and md_start=0.
- Decode (combinational from instruction_s2):
  - Any op not listed below gives alu_sel=0.
  - LUI → 15.
  - R-type: bit30 selects SUB/SRA.
  - I-type: bit30 selects SRA only, for funct3=101. ADDI is always ADD.
  - mem_wen is internal = STORE & valid_s2 & ~stall & ~flush.
- Register usage:
  - rs1 is used by everything except LUI/AUIPC/JAL.
  - rs2 is used by R-type, STORE and BRANCH.
- Forwarding, for each used rs ≠ x0:
  - rs1_sel/rs2_sel = 10 if it matches rd_s3 with valid_s3 & regwen_s3 & ~is_load_s3.
  - Otherwise 01 if it matches rd_s4 with regwen_s4.
  - Otherwise 00.
  - s3 has priority over s4.
  - Unused or x0 operands → 00.
- Load-use hazard:
  - Condition: valid_s3 & is_load_s3 & rd_s3≠0 & rd_s3 matches a used rs of a valid s2 instruction.
  - Response: stall=1 for exactly one cycle, and s3 gets a bubble (valid_s3←0).
  - Next cycle the load is in s4, so the operand forwards with select 01.
- M-op FSM (MULDIV_EN=1):
  - IDLE → BUSY when a valid, unflushed M op is in s2 and there is no load-use stall.
    - md_start=1 in that cycle.
    - Counter is loaded with N−1 (N = MUL_CYCLES for funct3[2]=0, else DIV_CYCLES).
  - BUSY:
    - stall=1; the counter decrements each cycle.
    - At counter==0 → DONE.
  - DONE:
    - stall=0; the instruction advances into s3 with regwen.
    - → IDLE.
  - Total occupancy: N+1 cycles, of which N are stalled.
  - If N=1, IDLE goes directly to DONE (one stall cycle).
- Flush:
  - Takes priority over everything.
  - stall is forced to 0 in the same cycle.
  - FSM → IDLE, counter → 0, md_start suppressed.
  - s3 registers receive a bubble.
- s3 register update:
  - Each cycle, if stall or flush or ~valid_s2: bubble (all 0).
  - Otherwise capture valid=1, rd, regwen (not STORE/BRANCH, and rd≠0), mem_wen, is_load.
- Simultaneous events: a load-use stall with an M op in s2 delays FSM entry by one cycle.

Test Plan:
- Reset mid-BUSY (DIV, counter=10), rst_n low 1 cycle → FSM IDLE, stall=0, valid_s3=0 immediately, no md_start after release until a new M op arrives.
- `add x3,x1,x2` in s3, then `sub x5,x3,x3` in s2 → rs1_sel=rs2_sel=10, alu_sel=12, no stall; same pair with the producer in s4 instead → selects=01.
- `lw x4,0(x1)` in s3, then `addi x6,x4,1` in s2 → stall=1 for 1 cycle, valid_s3=0 next; then rs1_sel=01, alu_sel=0, stall=0.
- `div x7,x8,x9` with DIV_CYCLES=33 → md_start one pulse, md_op=100, stall high 33 cycles, then DONE: valid_s3=1, rd_s3=7, regwen_s3=1.
- `mul` in BUSY, flush=1 → stall=0 same cycle, FSM IDLE, valid_s3=0; `srai x1,x1,3` then gives alu_sel=13 and `addi` with imm bit30 set gives alu_sel=0.
- `sw x0,4(x2)` with rd field≠0 → mem_wen_s3=1, regwen_s3=0, rs2_sel=00 (x0).
